// File: rtl/arq_pkg.sv
// rtl/arq_pkg.sv - shared types, constants and helpers for the stop-and-wait ARQ sender
package arq_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_ACK = 2'd2,
      FAIL     = 2'd3
   } arq_state_e;

   localparam logic ACK_OK  = 1'b1;
   localparam logic ACK_NAK = 1'b0;

   function automatic int arq_frame_w(input int data_w);
      return 2 * data_w + 1;
   endfunction

   // Callers truncate to their payload width, which yields the mod 2^DATA_W sum.
   function automatic logic [31:0] arq_checksum(input logic [31:0] data, input logic seq);
      return ~(data + {31'b0, seq});
   endfunction

endpackage

// File: rtl/arq_timeout_timer.sv
// rtl/arq_timeout_timer.sv - ACK timeout counter; expired while enabled and count reaches TIMEOUT-1
module arq_timeout_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired = enable && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/arq_sender.sv
// rtl/arq_sender.sv - stop-and-wait ARQ transmit stage with seq bit, checksum and bounded retry
// Optional ARQ_STATS_EN adds frames_sent / words_ok counters.
module arq_sender
   import arq_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int TIMEOUT   = 64,
   parameter int MAX_RETRY = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [2*DATA_W:0]       tx_frame,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   input  logic                    ack_valid,
   input  logic                    ack_ok,
   input  logic                    ack_seq,
   output logic [3:0]              retry_cnt,
   output logic                    busy,
`ifdef ARQ_STATS_EN
   output logic [15:0]             frames_sent,
   output logic [15:0]             words_ok,
`endif
   output logic                    fail
);

   localparam int FRAME_W = arq_frame_w(DATA_W);
   localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

   arq_state_e           state_q, state_d;
   logic                 seq_q, seq_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic [3:0]           retry_q, retry_d;
   logic                 in_ready_q, in_ready_d;
   logic [DATA_W-1:0]    chk;
   logic                 timer_clr;
   logic                 timer_exp;
   logic                 good_ack;
   logic                 bad_ack;
   logic                 tx_fire;

   arq_timeout_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (timer_clr),
      .enable (state_q == WAIT_ACK),
      .expired(timer_exp)
   );

   assign chk      = DATA_W'(arq_checksum(32'(in_data), seq_q));
   assign tx_valid = (state_q == SEND);
   assign tx_fire  = tx_valid && tx_ready;
   assign good_ack = (state_q == WAIT_ACK) && ack_valid && (ack_ok == ACK_OK) && (ack_seq == seq_q);
   assign bad_ack  = (state_q == WAIT_ACK) && ack_valid && !good_ack;

   always_comb begin
      state_d   = state_q;
      seq_d     = seq_q;
      frame_d   = frame_q;
      retry_d   = retry_q;
      timer_clr = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               frame_d = {seq_q, in_data, chk};
               state_d = SEND;
            end
         end
         SEND: begin
            if (tx_ready) begin
               timer_clr = 1'b1;
               state_d   = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            // A good ACK takes priority over a simultaneous timeout.
            if (good_ack) begin
               seq_d   = ~seq_q;
               retry_d = '0;
               state_d = IDLE;
            end else if (bad_ack || timer_exp) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = SEND;
               end else begin
                  state_d = FAIL;
               end
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Registered so in_ready stays low through reset and rises on the first edge after.
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         seq_q      <= 1'b0;
         frame_q    <= '0;
         retry_q    <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         frame_q    <= frame_d;
         retry_q    <= retry_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign tx_frame  = frame_q;
   assign retry_cnt = retry_q;
   assign busy      = (state_q != IDLE);
   assign fail      = (state_q == FAIL);

`ifdef ARQ_STATS_EN
   logic [15:0] frames_sent_q, frames_sent_d;
   logic [15:0] words_ok_q, words_ok_d;

   always_comb begin
      frames_sent_d = frames_sent_q;
      words_ok_d    = words_ok_q;
      if (tx_fire) begin
         frames_sent_d = frames_sent_q + 16'd1;
      end
      if (good_ack) begin
         words_ok_d = words_ok_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_sent_q <= '0;
         words_ok_q    <= '0;
      end else begin
         frames_sent_q <= frames_sent_d;
         words_ok_q    <= words_ok_d;
      end
   end

   assign frames_sent = frames_sent_q;
   assign words_ok    = words_ok_q;
`else
   logic unused_tx_fire;
   assign unused_tx_fire = tx_fire;
`endif

endmodule

// File: tb/tb_arq_sender.sv
// tb/tb_arq_sender.sv - directed self-checking bench for arq_sender (DATA_W=8, TIMEOUT=64, MAX_RETRY=3)
module tb_arq_sender;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [16:0] tx_frame;
   logic        tx_valid;
   logic        tx_ready;
   logic        ack_valid;
   logic        ack_ok;
   logic        ack_seq;
   logic [3:0]  retry_cnt;
   logic        busy;
   logic        fail;
`ifdef ARQ_STATS_EN
   logic [15:0] frames_sent;
   logic [15:0] words_ok;
   int          exp_frames = 0;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int n;

   arq_sender #(
      .DATA_W   (8),
      .TIMEOUT  (64),
      .MAX_RETRY(3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx_frame (tx_frame),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .ack_valid(ack_valid),
      .ack_ok   (ack_ok),
      .ack_seq  (ack_seq),
      .retry_cnt(retry_cnt),
      .busy     (busy),
`ifdef ARQ_STATS_EN
      .frames_sent(frames_sent),
      .words_ok (words_ok),
`endif
      .fail     (fail)
   );

   always #5 clk = ~clk;

`ifdef ARQ_STATS_EN
   always @(negedge clk) begin
      if (!rst_n) exp_frames = 0;
      else if (tx_valid && tx_ready) exp_frames = exp_frames + 1;
   end
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Edges until tx_valid (or fail) rises; 200 means it never did.
   task automatic wait_for(input bit on_fail, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!(on_fail ? fail : tx_valid) && cnt < 200);
   endtask

   task automatic send_ack(input logic ok, input logic sq);
      ack_valid = 1'b1;
      ack_ok    = ok;
      ack_seq   = sq;
      step();
      ack_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; tx_ready = 1'b0;
      ack_valid = 1'b0; ack_ok = 1'b0; ack_seq = 1'b0;
      repeat (3) step();
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_outputs", {tx_frame, tx_valid, busy, fail, retry_cnt}, 0);
      rst_n = 1'b1;
      check_eq("in_ready_before_edge", in_ready, 0);
      step();
      check_eq("in_ready_after_edge", in_ready, 1);

      // Word 0x3C, seq 0, immediate handshake and good ACK.
      in_data = 8'h3C; in_valid = 1'b1; tx_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("w1_tx_valid", tx_valid, 1);
      check_eq("w1_frame", tx_frame, 17'h03CC3);
      check_eq("w1_in_ready_low", in_ready, 0);
      step();
      check_eq("w1_wait_state", {tx_valid, busy}, 2'b01);
      send_ack(1'b1, 1'b0);
      check_eq("w1_idle", {in_ready, busy, retry_cnt}, 6'b10_0000);

      // Word 0x10, seq 1, with tx_ready held low for 10 cycles.
      in_data = 8'h10; in_valid = 1'b1; tx_ready = 1'b0;
      step();
      in_valid = 1'b0;
      check_eq("w2_frame", tx_frame, 17'h110EE);
      for (int i = 0; i < 10; i++) begin
         step();
         check_eq("w2_hold", {tx_valid, tx_frame}, {1'b1, 17'h110EE});
      end
      tx_ready = 1'b1;
      step();
      check_eq("w2_handshake", tx_valid, 0);
      send_ack(1'b1, 1'b0);
      check_eq("w2_wrongseq_retry", retry_cnt, 1);
      check_eq("w2_resend", {tx_valid, tx_frame}, {1'b1, 17'h110EE});
      step();
      send_ack(1'b0, 1'b1);
      check_eq("w2_nak_retry", retry_cnt, 2);
      check_eq("w2_resend2", {tx_valid, tx_frame}, {1'b1, 17'h110EE});
      step();
      send_ack(1'b1, 1'b1);
      check_eq("w2_done", {in_ready, retry_cnt}, 5'b1_0000);
`ifdef ARQ_STATS_EN
      check_eq("stats_words_ok_2", words_ok, 2);
`endif

      // Word 0xFF, seq 0: good ACK on the expiry cycle wins.
      in_data = 8'hFF; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("w3_frame", tx_frame, 17'h0FF00);
      step();
      repeat (63) step();
      send_ack(1'b1, 1'b0);
      check_eq("w3_ack_wins", {in_ready, tx_valid, retry_cnt}, 6'b10_0000);
      repeat (3) step();
      check_eq("w3_no_resend", tx_valid, 0);

      // Word 0xFF, seq 1: checksum wrap, then timeouts until failure.
      in_data = 8'hFF; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("w4_frame", tx_frame, 17'h1FFFF);
      step();
      for (int r = 1; r <= 3; r++) begin
         wait_for(1'b0, n);
         check_eq("w4_timeout_cycles", n, 64);
         check_eq("w4_retry_cnt", retry_cnt, r);
         check_eq("w4_frame_same", tx_frame, 17'h1FFFF);
         step();
      end
      wait_for(1'b1, n);
      check_eq("w4_fail_cycles", n, 64);
      check_eq("w4_fail_state", {fail, in_ready, tx_valid, busy, retry_cnt}, 8'b1001_0011);
      ack_valid = 1'b1; ack_ok = 1'b1; ack_seq = 1'b1; in_valid = 1'b1;
      repeat (5) step();
      ack_valid = 1'b0; in_valid = 1'b0;
      check_eq("w4_fail_sticky", {fail, in_ready, tx_valid}, 3'b100);

      // Reset out of FAIL, then async reset in WAIT_ACK with retry_cnt=1.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      in_data = 8'h3C; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("w5_seq_reset_frame", tx_frame, 17'h03CC3);
      step();
      send_ack(1'b0, 1'b0);
      check_eq("w5_retry", retry_cnt, 1);
      step();
      repeat (5) step();
`ifdef ARQ_STATS_EN
      check_eq("stats_frames_sent", frames_sent, exp_frames);
      check_eq("stats_words_ok_0", words_ok, 0);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_frame", tx_frame, 0);
      check_eq("async_rst_flags", {tx_valid, in_ready, busy, fail, retry_cnt}, 0);
`ifdef ARQ_STATS_EN
      check_eq("async_rst_stats", {frames_sent, words_ok}, 0);
`endif
      step();
      rst_n = 1'b1;
      repeat (5) step();
      check_eq("post_rst_no_frame", {tx_valid, in_ready, busy}, 3'b010);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/arq_sender.md
Name: arq_sender

Overview:
Stop-and-wait ARQ transmit stage feeding the channel/receiver path inside `main`.
- Accepts one data word at a time from the source.
- Wraps the word into a frame with a 1-bit sequence number and a checksum, then presents the frame downstream.
- Waits for an ACK or NAK; retransmits on NAK, wrong sequence or timeout.
- Declares failure after MAX_RETRY retransmissions.

Parameters:
DATA_W, 8, payload width in bits.
TIMEOUT, 64, cycles spent in WAIT_ACK before a timeout; legal range 2..65535.
MAX_RETRY, 3, retransmissions allowed per word before entering FAIL; legal range 0..15.

Ports:
clk  in  1  system clock; rising edge.
rst_n  in  1  reset.
in_data  in  DATA_W  payload from the source.
in_valid  in  1  source has a word.
in_ready  out  1  sender can accept a word.
tx_frame  out  2*DATA_W+1  frame to the channel: {seq, data, chk}.
tx_valid  out  1  frame is valid.
tx_ready  in  1  channel accepts the frame.
ack_valid  in  1  response strobe from the receiver.
ack_ok  in  1  1 = ACK, 0 = NAK.
ack_seq  in  1  sequence number being acknowledged.
retry_cnt  out  4  retransmissions of the current word.
busy  out  1  high in any state other than IDLE.
fail  out  1  sticky failure flag.

Behaviour:
- Clock and reset (already decided):
  - One clock, clk.
  - Reset is asynchronous and active-low on rst_n.
  - rst_n=0 forces state=IDLE, seq=0, timer=0, retry_cnt=0, tx_frame=0, tx_valid=0, in_ready=0, busy=0, fail=0.
  - in_ready rises on the first clk edge after rst_n deasserts.
  - Reset in mid-operation abandons the frame in flight. No frame is emitted afterwards.
- Checksum: chk = ~((data + seq) mod 2^DATA_W). seq is zero-extended; the carry is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch data, build the frame, go to SEND.
  - tx_valid is asserted on the cycle after acceptance.
- SEND:
  - tx_valid=1. tx_frame is held stable until tx_ready.
  - On tx_valid&tx_ready: go to WAIT_ACK and clear the timer.
- WAIT_ACK:
  - timer increments every cycle.
  - Good ACK (ack_valid & ack_ok & ack_seq==seq): toggle seq, clear retry_cnt, return to IDLE. in_ready=1 on the next cycle.
  - Bad response (ack_valid & (!ack_ok | ack_seq!=seq)) or timer==TIMEOUT-1 is a retry event:
    - retry_cnt < MAX_RETRY: increment retry_cnt, go to SEND with the same frame and the same seq.
    - retry_cnt == MAX_RETRY: go to FAIL.
- FAIL:
  - fail=1, in_ready=0, tx_valid=0.
  - Left only by reset.
- Boundary and priority rules:
  - A good ACK in the same cycle as timeout counts as success (ACK wins).
  - ack_valid outside WAIT_ACK is ignored.
  - in_valid outside IDLE is ignored; in_ready is 0 there.
  - seq wraps 1→0 on toggle.
  - retry_cnt saturates at MAX_RETRY.
- Throughput: at most one word in flight. The minimum per-word cycle is IDLE, SEND, then WAIT_ACK, i.e. 3 cycles.

Optional Feature:
Macro ARQ_STATS_EN.
- Defined:
  - Adds output frames_sent [15:0]: increments on every tx_valid&tx_ready, including retransmissions.
  - Adds output words_ok [15:0]: increments on every good ACK.
  - Both counters reset to 0 and wrap at 16'hFFFF→0.
- Undefined:
  - Neither port nor its logic exists.
  - All other behaviour is identical.

Decomposition:
- Package arq_pkg holds:
  - state enum {IDLE, SEND, WAIT_ACK, FAIL}
  - frame-width constant / function (2*DATA_W+1)
  - checksum function
  - the ACK/NAK encoding constants
- Sub-module arq_timeout_timer:
  - Inputs: clear and enable.
  - Output: expired at TIMEOUT-1.
  - Width is derived from TIMEOUT.

Test Plan:
- Reset, then in_data=8'h3C with in_valid=1 and tx_ready=1 → tx_frame=17'h03CC3, tx_valid high one cycle after acceptance. Then ack_valid=1, ack_ok=1, ack_seq=0 → IDLE, seq=1.
- Second word 8'h10 → tx_frame=17'h110EE. Supply ACK with ack_seq=0 → treated as a bad response: retry_cnt=1, identical frame resent.
- No ACK after send → frame re-presented exactly TIMEOUT(64) cycles after the tx handshake. Three timeouts, then a fourth with MAX_RETRY=3 → fail=1 and stays 1; in_ready=0.
- Hold tx_ready=0 for 10 cycles in SEND → tx_valid and tx_frame stable; the timer does not run.
- Good ACK on the same cycle as timer expiry → success, retry_cnt=0, no retransmission.
- Assert rst_n=0 in WAIT_ACK → all outputs reach reset values immediately, without a clock edge. With ARQ_STATS_EN, frames_sent and words_ok also reset to 0.
